// File: rtl/char_buf_arbiter_if.sv
// Write-side bus of the character buffer arbiter: two requester channels,
// clear handshake, vblank qualifier and the registered buffer write port.
interface char_buf_arbiter_if #(
    parameter int ROW_W = 2,
    parameter int COL_W = 4,
    parameter int CW    = 6
);
    logic             clr_req;
    logic             clr_busy;
    logic             req0;
    logic [ROW_W-1:0] row0;
    logic [COL_W-1:0] col0;
    logic [CW-1:0]    data0;
    logic             ack0;
    logic             req1;
    logic [ROW_W-1:0] row1;
    logic [COL_W-1:0] col1;
    logic [CW-1:0]    data1;
    logic             ack1;
    logic             vblank;
    logic             buf_we;
    logic [ROW_W-1:0] buf_row;
    logic [COL_W-1:0] buf_col;
    logic [CW-1:0]    buf_data;
    logic             wr_err;

    modport master (
        output clr_req, req0, row0, col0, data0, req1, row1, col1, data1, vblank,
        input  clr_busy, ack0, ack1, buf_we, buf_row, buf_col, buf_data, wr_err
    );

    modport slave (
        input  clr_req, req0, row0, col0, data0, req1, row1, col1, data1, vblank,
        output clr_busy, ack0, ack1, buf_we, buf_row, buf_col, buf_data, wr_err
    );
endinterface

// File: rtl/char_buf_arbiter.sv
// Round-robin arbiter and full-screen clear sequencer for the text character buffer.
// Define CHAR_BUF_BLANK_ONLY_EN to restrict new writes and clear steps to vblank.
module char_buf_arbiter #(
    parameter int             ROWS       = 4,
    parameter int             COLS       = 9,
    parameter int             ROW_W      = 2,
    parameter int             COL_W      = 4,
    parameter int             CW         = 6,
    parameter logic [CW-1:0]  BLANK_CODE = 6'o40
) (
    input  logic               CLOCK_50,
    input  logic               ar,
    char_buf_arbiter_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [CW-1:0]    data;
    } wr_req_t;

    logic [1:0]       state;
    logic             last;
    logic [ROW_W-1:0] cnt_row;
    logic [COL_W-1:0] cnt_col;
    logic             we_q, ack0_q, ack1_q, err_q, busy_q;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;
    logic [CW-1:0]    data_q;

    wr_req_t rq0, rq1, win_rq;
    logic    allow, win, grant, in_range, clr_done, clr_step;

`ifdef CHAR_BUF_BLANK_ONLY_EN
    assign allow = bus.vblank;
`else
    logic unused_vblank;
    assign unused_vblank = bus.vblank;
    assign allow = 1'b1;
`endif

    assign rq0    = {bus.row0, bus.col0, bus.data0};
    assign rq1    = {bus.row1, bus.col1, bus.data1};
    // Under contention the requester that did not win last time goes first.
    assign win    = (bus.req0 & bus.req1) ? ~last : bus.req1;
    assign win_rq = win ? rq1 : rq0;
    assign grant  = ~bus.clr_req & (bus.req0 | bus.req1) & allow;

    assign in_range = ({1'b0, win_rq.row} < (ROW_W+1)'(ROWS)) &&
                      ({1'b0, win_rq.col} < (COL_W+1)'(COLS));

    // The counter wraps to (0,0) as the last cell goes out, so a wrapped
    // counter with the strobe still up marks the final write of the clear.
    assign clr_done = we_q && (cnt_row == '0) && (cnt_col == '0);
    assign clr_step = allow && ((state == S_IDLE && bus.clr_req) ||
                                (state == S_CLEAR && !clr_done));

    always_ff @(posedge CLOCK_50 or negedge ar) begin
        if (!ar) begin
            state   <= S_IDLE;
            last    <= 1'b1;
            cnt_row <= '0;
            cnt_col <= '0;
            we_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            data_q  <= '0;
        end else begin
            we_q   <= 1'b0;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.clr_req) begin
                        state  <= S_CLEAR;
                        busy_q <= 1'b1;
                    end else if (grant) begin
                        state  <= S_WRITE;
                        last   <= win;
                        row_q  <= win_rq.row;
                        col_q  <= win_rq.col;
                        data_q <= win_rq.data;
                        we_q   <= in_range;
                        err_q  <= ~in_range;
                        ack0_q <= ~win;
                        ack1_q <= win;
                    end
                end
                S_WRITE: state <= S_IDLE;
                S_CLEAR: begin
                    if (clr_done) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (clr_step) begin
                we_q   <= 1'b1;
                row_q  <= cnt_row;
                col_q  <= cnt_col;
                data_q <= BLANK_CODE;
                if (cnt_col == COL_W'(COLS-1)) begin
                    cnt_col <= '0;
                    cnt_row <= (cnt_row == ROW_W'(ROWS-1)) ? '0 : cnt_row + 1'b1;
                end else begin
                    cnt_col <= cnt_col + 1'b1;
                end
            end
        end
    end

    assign bus.buf_we   = we_q;
    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.wr_err   = err_q;
    assign bus.clr_busy = busy_q;
    assign bus.buf_row  = row_q;
    assign bus.buf_col  = col_q;
    assign bus.buf_data = data_q;

endmodule
